// File: rtl/aes_core_arbiter.sv
// Round-robin front end for a single shared AES encrypt core.
// One requester's block and the shared key are latched at accept, the core
// is started with a one-cycle pulse, and its result (or a watchdog abort)
// is handed back to the granted requester as a one-cycle response.
//
// Handshake: in IDLE, req_ready is the one-hot grant and an accept happens on
// any edge where req_valid[g] && req_ready[g]; requesters hold req_valid and
// req_data until accepted. Responses have no backpressure: resp_valid is a
// single-cycle pulse and resp_data/resp_err are only meaningful alongside it.
module aes_core_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*128-1:0] req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [255:0]           key,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [127:0]           resp_data,
    output logic                   resp_err,
    output logic                   busy,
    output logic                   core_ready,
    output logic [127:0]           core_data_in,
    output logic [255:0]           core_key,
    input  logic [127:0]           core_data_out,
    input  logic                   core_valid,
    output logic [1:0]             dbg_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gnt_q;
    logic [IDX_W-1:0]   grant_idx;
    logic               any_req;
    logic [127:0]       sel_data;
    logic [127:0]       blk_q;
    logic [255:0]       key_q;
    logic [CNT_W-1:0]   cnt;
    logic [127:0]       res_data_q;
    logic               res_err_q;

    // Round-robin pick: lowest set request at or above ptr, else lowest overall.
    always_comb begin
        any_req   = |req_valid;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) grant_idx = IDX_W'(i);
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (IDX_W'(i) >= ptr)) grant_idx = IDX_W'(i);
        end
    end

    // Select the granted requester's plaintext block.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) sel_data = req_data[128*i +: 128];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and state-driven handshake outputs.
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = '0;
        resp_data  = '0;
        resp_err   = 1'b0;
        busy       = 1'b1;
        core_ready = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (any_req) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        req_ready[i] = (grant_idx == IDX_W'(i));
                    end
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                core_ready = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the last watchdog cycle still counts as success.
                if (core_valid || (cnt == CNT_LAST)) state_nxt = S_RESP;
            end
            S_RESP: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    resp_valid[i] = (gnt_q == IDX_W'(i));
                end
                resp_data = res_data_q;
                resp_err  = res_err_q;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Accept latching, round-robin pointer, watchdog and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            gnt_q      <= '0;
            blk_q      <= '0;
            key_q      <= '0;
            cnt        <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        blk_q <= sel_data;
                        key_q <= key;
                        gnt_q <= grant_idx;
                        ptr   <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
                    end
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (core_valid) begin
                        res_data_q <= core_data_out;
                        res_err_q  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        res_data_q <= '0;
                        res_err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_data_in = blk_q;
    assign core_key     = key_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: behavioural core model with programmable
// latency, round-robin grant model, and an expected-response queue.
module tb_aes_core_arbiter;

    localparam int NR = 4;
    localparam int TO = 16;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*128-1:0] req_data;
    logic [NR-1:0]     req_ready;
    logic [255:0]      key;
    logic [NR-1:0]     resp_valid;
    logic [127:0]      resp_data;
    logic              resp_err;
    logic              busy;
    logic              core_ready;
    logic [127:0]      core_data_in;
    logic [255:0]      core_key;
    logic [127:0]      core_data_out;
    logic              core_valid;
    logic [1:0]        dbg_state;

    int n_vec     = 0;
    int n_err     = 0;
    int cyc       = 0;
    int exp_ptr   = 0;
    int core_lat  = 1;
    int stray_cyc = -1;
    bit core_mute = 1'b1;

    logic [127:0] exp_q[$];

    aes_core_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .key           (key),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .busy          (busy),
        .core_ready    (core_ready),
        .core_data_in  (core_data_in),
        .core_key      (core_key),
        .core_data_out (core_data_out),
        .core_valid    (core_valid),
        .dbg_state     (dbg_state)
    );

    // Clock and cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "time limit");
    end

    // Stand-in cipher used by the core model and the expectations.
    function automatic logic [127:0] cipher(input logic [127:0] d, input logic [255:0] k);
        return {d[63:0], d[127:64]} ^ k[127:0] ^ k[255:128] ^ 128'h5a5a_0001;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] rand256();
        return {rand128(), rand128()};
    endfunction

    // Reference grant: first pending requester scanning upward from p, modulo NR.
    function automatic int model_grant(input logic [NR-1:0] m, input int p);
        logic [NR-1:0] sh;
        for (int k = 0; k < NR; k++) begin
            sh = m >> ((p + k) % NR);
            if (sh[0]) return (p + k) % NR;
        end
        return -1;
    endfunction

    // Core model: result core_lat cycles after the start pulse; optional stray pulse.
    initial begin
        int           fire_cyc;
        bit           pending;
        logic [127:0] lat_d;
        logic [255:0] lat_k;
        pending       = 1'b0;
        fire_cyc      = 0;
        lat_d         = '0;
        lat_k         = '0;
        core_valid    = 1'b0;
        core_data_out = '0;
        forever begin
            @(negedge clk);
            core_valid    = 1'b0;
            core_data_out = rand128();
            if (rst) pending = 1'b0;
            if (pending && (cyc == fire_cyc)) begin
                core_valid    = 1'b1;
                core_data_out = cipher(lat_d, lat_k);
                pending       = 1'b0;
            end
            if (cyc == stray_cyc) core_valid = 1'b1;
            if (core_ready && !core_mute) begin
                pending  = 1'b1;
                fire_cyc = cyc + core_lat;
                lat_d    = core_data_in;
                lat_k    = core_key;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = '0;
        core_mute = 1'b1;
        tick();
        tick();
        rst     = 1'b0;
        exp_ptr = 0;
        exp_q.delete();
    endtask

    task automatic post(input int i, input logic [127:0] d);
        logic [NR-1:0] b;
        b = NR'(1) << i;
        req_valid = req_valid | b;
        req_data[128*i +: 128] = d;
    endtask

    task automatic post_mask(input logic [NR-1:0] m);
        for (int j = 0; j < NR; j++) begin
            if (m[j] && !req_valid[j]) post(j, rand128());
        end
    endtask

    // One full transaction from the currently pending requests.
    task automatic run_txn(input int lat, input bit mute);
        int            g;
        int            a_cyc;
        int            exp_cyc;
        int            waited;
        bit            got;
        bit            exp_err;
        logic [127:0]  blk;
        logic [127:0]  exp_data;
        logic [255:0]  key_used;
        logic [NR-1:0] oh;
        core_lat  = lat;
        core_mute = mute;
        g  = model_grant(req_valid, exp_ptr);
        oh = NR'(1) << g;
        #1;
        check("idle_busy", 256'(busy), 256'(0));
        check("idle_resp_valid", 256'(resp_valid), 256'(0));
        check("req_ready", 256'(req_ready), 256'(oh));
        a_cyc    = cyc;
        blk      = '0;
        for (int j = 0; j < NR; j++) begin
            if (j == g) blk = req_data[128*j +: 128];
        end
        key_used = key;
        exp_ptr  = (g + 1) % NR;
        if (!mute && lat <= TO) begin
            exp_cyc  = a_cyc + 2 + lat;
            exp_err  = 1'b0;
            exp_data = cipher(blk, key_used);
        end else begin
            exp_cyc  = a_cyc + 2 + TO;
            exp_err  = 1'b1;
            exp_data = '0;
        end
        exp_q.push_back(exp_data);

        tick();
        req_valid = req_valid & ~oh;
        key       = rand256();
        #1;
        check("issue_core_ready", 256'(core_ready), 256'(1));
        check("issue_data_in", 256'(core_data_in), 256'(blk));
        check("issue_key", core_key, key_used);
        check("issue_req_ready", 256'(req_ready), 256'(0));
        check("issue_busy", 256'(busy), 256'(1));

        got    = 1'b0;
        waited = 0;
        while (!got && waited < TO + 8) begin
            tick();
            #1;
            waited++;
            if (resp_valid != '0) begin
                got = 1'b1;
            end else begin
                check("wait_req_ready", 256'(req_ready), 256'(0));
                check("wait_core_ready", 256'(core_ready), 256'(0));
            end
        end
        check("resp_cycle", 256'(got ? cyc : -1), 256'(exp_cyc));
        check("resp_valid", 256'(resp_valid), 256'(oh));
        exp_data = exp_q.pop_front();
        check("resp_data", 256'(resp_data), 256'(exp_data));
        check("resp_err", 256'(resp_err), 256'(exp_err));
        check("resp_busy", 256'(busy), 256'(1));
        tick();
    endtask

    // Directed and random sequence.
    initial begin
        logic [NR-1:0] oh;
        int            g;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        key       = '0;

        // Reset values
        apply_reset();
        #1;
        check("rst_req_ready", 256'(req_ready), 256'(0));
        check("rst_resp_valid", 256'(resp_valid), 256'(0));
        check("rst_resp_data", 256'(resp_data), 256'(0));
        check("rst_resp_err", 256'(resp_err), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_core_ready", 256'(core_ready), 256'(0));
        check("rst_core_data_in", 256'(core_data_in), 256'(0));
        check("rst_core_key", core_key, 256'(0));
        tick();

        // Single request, L = 14
        key = 256'd1;
        post(0, 128'd1);
        run_txn(14, 1'b0);

        // Round-robin with all requesters re-asserting
        apply_reset();
        repeat (6) begin
            post_mask(4'b1111);
            run_txn($urandom_range(1, 10), 1'b0);
        end

        // Pointer wrap and skip
        run_txn(4, 1'b0);
        req_valid = '0;
        post_mask(4'b0011);
        run_txn(3, 1'b0);
        run_txn(2, 1'b0);
        req_valid = '0;
        post_mask(4'b1000);
        run_txn(5, 1'b0);
        post_mask(4'b1000);
        run_txn(1, 1'b0);

        // Timeout, last-cycle valid, valid landing in RESP, then normal
        post_mask(4'b0010);
        run_txn(5, 1'b1);
        post_mask(4'b0100);
        run_txn(TO, 1'b0);
        post_mask(4'b0001);
        run_txn(TO + 1, 1'b0);
        post_mask(4'b1000);
        run_txn(3, 1'b0);

        // Stray core_valid while idle
        req_valid = '0;
        stray_cyc = cyc + 1;
        repeat (4) begin
            tick();
            #1;
            check("stray_resp_valid", 256'(resp_valid), 256'(0));
            check("stray_busy", 256'(busy), 256'(0));
            check("stray_core_ready", 256'(core_ready), 256'(0));
        end
        stray_cyc = -1;
        tick();
        post_mask(4'b0010);
        run_txn(6, 1'b0);

        // Reset in the middle of WAIT
        core_mute = 1'b1;
        post(1, rand128());
        g  = model_grant(req_valid, exp_ptr);
        oh = NR'(1) << g;
        #1;
        check("mid_req_ready", 256'(req_ready), 256'(oh));
        tick();
        req_valid = '0;
        #1;
        check("mid_issue", 256'(core_ready), 256'(1));
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        exp_ptr = 0;
        #1;
        check("mid_rst_req_ready", 256'(req_ready), 256'(0));
        check("mid_rst_resp_valid", 256'(resp_valid), 256'(0));
        check("mid_rst_resp_data", 256'(resp_data), 256'(0));
        check("mid_rst_resp_err", 256'(resp_err), 256'(0));
        check("mid_rst_busy", 256'(busy), 256'(0));
        check("mid_rst_core_ready", 256'(core_ready), 256'(0));
        check("mid_rst_core_data_in", 256'(core_data_in), 256'(0));
        check("mid_rst_core_key", core_key, 256'(0));
        repeat (20) begin
            tick();
            #1;
            check("mid_rst_no_resp", 256'(resp_valid), 256'(0));
        end
        tick();
        post_mask(4'b0101);
        run_txn(4, 1'b0);
        run_txn(4, 1'b0);
        post_mask(4'b0100);
        run_txn(4, 1'b0);

        // Random traffic
        repeat (30) begin
            post_mask(NR'($urandom_range(1, (1 << NR) - 1)));
            run_txn($urandom_range(1, TO + 3), ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_core_arbiter.md
# aes_core_arbiter

Round-robin arbiter and sequencer that shares one `AESEncrypt` core among `NUM_REQ` requesters. It accepts one 128-bit plaintext block at a time from the winning requester, latches the block and the shared 256-bit key, and pulses the core's `ready` start input. It then waits for the core's `valid` and returns the ciphertext to the granted requester as a one-cycle response pulse. A watchdog aborts a transaction whose core never responds.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 1024: maximum WAIT cycles before abort, ≥ 2.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input `NUM_REQ`: requester i has a block pending.
- `req_data` input `NUM_REQ*128`: block of requester i in bits `[128*i +: 128]`.
- `req_ready` output `NUM_REQ`: one-hot accept, combinational in IDLE.
- `key` input 256: shared key, sampled at accept.
- `resp_valid` output `NUM_REQ`: one-hot, one-cycle result pulse.
- `resp_data` output 128: ciphertext, valid with `resp_valid`.
- `resp_err` output 1: qualifies `resp_valid`; 1 = timeout abort.
- `busy` output 1: high in every state except IDLE.
- `core_ready` output 1: one-cycle start pulse to the core.
- `core_data_in` output 128: latched block, held stable ISSUE through RESP.
- `core_key` output 256: latched key, held stable ISSUE through RESP.
- `core_data_out` input 128: core result.
- `core_valid` input 1: core result valid.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `req_valid` is set, grant g = first set bit scanning upward from pointer `ptr`, wrapping modulo `NUM_REQ`.
  - `req_ready[g]`=1 that cycle.
  - On the edge: latch `req_data[g]` and `key`, record g, set `ptr` = (g+1) mod `NUM_REQ`, go to ISSUE.
  - With no request, stay in IDLE and leave `ptr` unchanged.
- ISSUE: `core_ready`=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - Counter increments every cycle.
  - If `core_valid`=1: capture `core_data_out`, set err=0, go to RESP.
  - Else, when the counter reaches `TIMEOUT`-1: set data=0, err=1, go to RESP.
  - If `core_valid` arrives on the timeout cycle, valid wins (err=0).
- RESP: `resp_valid[g]`=1, `resp_data`/`resp_err` driven from the captured values; go to IDLE.
- `core_valid` seen in IDLE, ISSUE or RESP is ignored; no response is generated.
- `req_ready` is all-zero outside IDLE. Requesters hold `req_valid`/`req_data` until accepted.
- No backpressure on responses: a requester must sample `resp_data` in the `resp_valid` cycle.
- `key` changes affect only transactions accepted after the change.

## Timing
- Reset values: state IDLE, `ptr`=0, `req_ready`=0, `resp_valid`=0, `resp_data`=0, `resp_err`=0, `busy`=0, `core_ready`=0, `core_data_in`=0, `core_key`=0, counter=0.
- Reset asserted mid-transaction: return to IDLE on that edge; the in-flight result is discarded and no `resp_valid` is generated.
- Let L be the core latency, counted from the cycle `core_ready`=1 to the first cycle `core_valid`=1.
- Timing from accept cycle A: `core_ready` at A+1, `core_valid` at A+1+L, `resp_valid` at A+2+L.
- Back-to-back: the next accept can occur at A+3+L, so one transaction occupies L+3 cycles.
- Timeout path: `resp_valid` with `resp_err`=1 at A+2+`TIMEOUT`.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,`NUM_REQ`-1,0; no requester waits more than `NUM_REQ`-1 transactions.

## Test plan
- Single request: `req_valid`=0001, `req_data[0]`=128'd1, key=256'd1, core model L=14 -> `core_ready` at A+1 with `core_data_in`=1 and `core_key`=1; `resp_valid`=0001 with model ciphertext at A+16; `resp_err`=0.
- Round-robin: `req_valid`=1111 held, each requester re-asserting after its response -> grant order 0,1,2,3,0,1; `req_ready` one-hot and only in IDLE.
- Pointer wrap/skip: after grant to 2, `req_valid`=0011 -> grant 0, then 1; after grant 3 with `req_valid`=1000 only -> grant 3 again.
- Timeout: core never asserts valid, `TIMEOUT`=16 -> `resp_valid` at A+18, `resp_err`=1, `resp_data`=0; next request proceeds normally. Variant: `core_valid` on the last WAIT cycle -> `resp_err`=0.
- Stray valid: `core_valid` pulsed in IDLE and in RESP -> no extra `resp_valid`, no state change.
- Reset mid-WAIT: assert `rst` 5 cycles after ISSUE -> all outputs 0 next cycle, `ptr`=0, no response; the next `req_valid`=0100 is granted cleanly.
